// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS instruction memory: word/byte geometry,
// load FSM encoding and the fetch address check.
package mips_mem_pkg;
   localparam int WORD_W = 32;
   localparam int BYTE_W = 8;
   localparam int LANES  = WORD_W / BYTE_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FLUSH = 2'd2
   } ld_state_t;

   // A fetch is legal when it names a whole word inside the stored image.
   function automatic logic addr_ok(input logic [63:0] addr, input int depth);
      return (addr < (64'(depth) << 2)) && (addr[1:0] == 2'b00);
   endfunction
endpackage

// File: rtl/byte_word_packer.sv
// Assembles a big-endian byte stream into 32-bit words; a flush emits the
// partial word left-aligned with zero-filled low bytes.
module byte_word_packer
   import mips_mem_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clear,
   input  logic              byte_valid,
   input  logic [BYTE_W-1:0] byte_in,
   input  logic              flush,
   output logic [WORD_W-1:0] word,
   output logic              wr,
   output logic [1:0]        count
);
   logic [WORD_W-BYTE_W-1:0] acc;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc   <= '0;
         count <= '0;
      end else if (clear) begin
         acc   <= '0;
         count <= '0;
      end else if (byte_valid) begin
         acc   <= {acc[15:0], byte_in};
         count <= count + 2'd1;
      end else if (flush) begin
         acc   <= '0;
         count <= '0;
      end
   end

   // The fourth byte is written straight through so the store lands on the same edge.
   always_comb begin
      word = '0;
      wr   = 1'b0;
      if (byte_valid && count == 2'd3) begin
         wr   = 1'b1;
         word = {acc, byte_in};
      end else if (flush && count != 2'd0) begin
         wr = 1'b1;
         case (count)
            2'd1:    word = {acc[7:0], 24'h0};
            2'd2:    word = {acc[15:0], 16'h0};
            default: word = {acc, 8'h0};
         endcase
      end
   end
endmodule

// File: rtl/imem_loadable.sv
// Word-organised instruction memory with a synchronous fetch port and a
// run-time byte-stream load port; busy holds the CPU in reset while loading.
module imem_loadable
   import mips_mem_pkg::*;
#(
   parameter int ADDR_W = 31,
   parameter int DEPTH  = 256,
   parameter int CNT_W  = 9
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WORD_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              rd_err,
   input  logic              ld_start,
   input  logic              ld_valid,
   input  logic [BYTE_W-1:0] ld_byte,
   output logic              ld_ready,
   input  logic              ld_finish,
   output logic              busy,
   output logic [CNT_W-1:0]  words_loaded,
   output logic              ld_overflow
);
   localparam int IDX_W = $clog2(DEPTH);

   ld_state_t         state, state_next;
   logic [WORD_W-1:0] mem [DEPTH] = '{default: '0};
   logic [CNT_W-1:0]  ptr;
   logic              full, accept, pack_valid, pack_flush, pack_wr, mem_we;
   logic [WORD_W-1:0] pack_word;
   logic [1:0]        pack_count, count_after;

   assign full         = (ptr == CNT_W'(DEPTH));
   assign accept       = (state == LOAD) && ld_valid && !ld_start;
   assign pack_valid   = accept && !full;
   assign pack_flush   = (state == FLUSH) && !ld_start;
   assign mem_we       = pack_wr && !full;
   assign count_after  = pack_valid ? pack_count + 2'd1 : pack_count;
   assign ld_ready     = (state == LOAD);
   assign busy         = (state != IDLE);
   assign words_loaded = ptr;

   byte_word_packer u_packer (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (ld_start),
      .byte_valid (pack_valid),
      .byte_in    (ld_byte),
      .flush      (pack_flush),
      .word       (pack_word),
      .wr         (pack_wr),
      .count      (pack_count)
   );

   // A finish in the same cycle as a byte is judged on the count including that byte.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (ld_start) state_next = LOAD;
         LOAD: begin
            if (ld_start)
               state_next = LOAD;
            else if (ld_finish)
               state_next = (count_after == 2'd0) ? IDLE : FLUSH;
         end
         FLUSH:   state_next = ld_start ? LOAD : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         ptr         <= '0;
         ld_overflow <= 1'b0;
      end else begin
         state <= state_next;
         if (ld_start) begin
            ptr         <= '0;
            ld_overflow <= 1'b0;
         end else begin
            if (mem_we)
               ptr <= ptr + CNT_W'(1);
            if ((accept || pack_wr) && full)
               ld_overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we)
         mem[ptr[IDX_W-1:0]] <= pack_word;
   end

   // Illegal fetches return zero, matching the old ROM's out-of-range behaviour.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
         rd_err   <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            if (addr_ok(64'(rd_addr), DEPTH)) begin
               rd_data <= mem[rd_addr[IDX_W+1:2]];
               rd_err  <= 1'b0;
            end else begin
               rd_data <= '0;
               rd_err  <= 1'b1;
            end
         end
      end
   end
endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
- Parametrised instruction memory for the MIPS cores, next generation of the fixed-content combinational program ROM.
- Word-organised storage, one synchronous read port for instruction fetch.
- Byte-stream load port lets a boot path (e.g. UART receiver) write a new program at run time without resynthesis.
- Top level holds the CPU in reset while `busy` is high.

Parameters:
- ADDR_W, 31, byte-address width of the fetch port.
- DEPTH, 256, number of 32-bit words stored; the legal byte range is 0 .. 4*DEPTH-1.
- CNT_W, 9, width of the word pointer/counter; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rd_en  in  1  fetch request.
- rd_addr  in  ADDR_W  fetch byte address.
- rd_data  out  32  fetched instruction.
- rd_valid  out  1  rd_data valid this cycle.
- rd_err  out  1  the fetch was out of range or misaligned.
- ld_start  in  1  pulse: begin a program load at word 0.
- ld_valid  in  1  ld_byte is valid.
- ld_byte  in  8  program byte, big-endian order (MSB of each word first).
- ld_ready  out  1  byte accepted when ld_valid && ld_ready.
- ld_finish  in  1  pulse: end of the program image.
- busy  out  1  load in progress.
- words_loaded  out  CNT_W  number of words written by the last or current load.
- ld_overflow  out  1  sticky flag: a byte arrived with memory full.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - rd_data=0, rd_valid=0, rd_err=0.
  - ld_ready=0, busy=0, words_loaded=0, ld_overflow=0.
  - FSM in IDLE; byte counter=0; word pointer=0.
  - Memory contents are not cleared by reset; they keep the optional init image, or zeros in simulation.
- Fetch port:
  - Latency is 1 cycle. If rd_en is high at edge N, then rd_valid=1 after edge N; otherwise rd_valid=0.
  - In range and aligned (rd_addr < 4*DEPTH and rd_addr[1:0]==0): rd_data=mem[rd_addr>>2], rd_err=0.
  - Out of range or misaligned: rd_data=0, rd_err=1. The zero return keeps the old ROM's out-of-range behaviour.
  - rd_data holds its value when rd_en=0.
  - A fetch is serviced in every state. A fetch of the same word written in the same cycle returns the old contents.
- Load FSM states: IDLE, LOAD, FLUSH.
  - IDLE:
    - ld_ready=0, busy=0.
    - ld_start -> LOAD: pointer=0, byte counter=0, words_loaded=0, ld_overflow=0.
  - LOAD:
    - busy=1, ld_ready=1.
    - Each accepted byte shifts into a 32-bit assembly register, MSB first, and the byte counter increments.
    - On the 4th byte the assembled word is written to mem[pointer] on the same edge; then pointer+1, words_loaded+1, byte counter=0.
    - If pointer==DEPTH when a byte is accepted: the byte is dropped and ld_overflow is set to 1 and held sticky. ld_ready stays 1 so the source never stalls.
    - ld_finish with byte counter 0 -> IDLE.
    - ld_finish with byte counter k (1..3) -> FLUSH.
    - If ld_finish and ld_valid arrive in the same cycle, the byte is accepted first and ld_finish is then evaluated with the updated counter.
  - FLUSH:
    - One cycle, ld_ready=0.
    - The partial word is written left-aligned, with zeros in the missing low-order bytes. It is dropped, and ld_overflow set, if pointer==DEPTH.
    - words_loaded+1 if the word was written; then -> IDLE.
  - ld_start while in LOAD or FLUSH restarts the load: pointer and counters are cleared, and memory already written stays as is.
- Reset during a load: aborts immediately to IDLE with busy=0. The memory keeps the words written so far.

Decomposition:
- Shared package `mips_mem_pkg`:
  - WORD_W=32 and the byte-lane constants.
  - FSM state encoding {IDLE, LOAD, FLUSH}.
  - The address-check function (range plus alignment).
- One sub-module: `byte_word_packer`. It takes bytes and a flush pulse, and outputs a word, a write pulse and a partial-byte count. This keeps the storage array and the fetch logic in the top level.

Test Plan:
- Reset, then fetch at 0x0: rd_valid=1 one cycle later, rd_err=0, rd_data=mem[0]. Fetch 0x402 (DEPTH=256): rd_data=0, rd_err=1. Fetch at 0x6: rd_err=1 (misaligned).
- ld_start; send bytes 08,00,00,03,3C,08,40,00; ld_finish: busy drops after 1 cycle, words_loaded=2. Fetch 0x0 returns 0x08000003; fetch 0x4 returns 0x3C084000.
- Load 5 bytes AA,BB,CC,DD,11, then ld_finish: FLUSH is entered, words_loaded=2, mem[1]=0x11000000.
- With DEPTH=4, load 17 bytes: words_loaded=4, ld_overflow=1; mem[3] holds bytes 13-16; the 17th byte is dropped.
- Assert reset_n=0 mid-load after 6 bytes: busy=0 asynchronously, mem[0] updated, mem[1] unchanged. A new ld_start clears ld_overflow and words_loaded.
- Fetch word 2 in the same cycle it is written by the loader: returns the old value. The next fetch returns the new value.
